// File: rtl/mbist_sequencer.sv
// Memory-BIST sequencer: walks the selected memory types, drives the March C decoder
// and gathers per-memory fail/timeout results into one pass/fail verdict per session.
module mbist_sequencer #(
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_MEM    = 8,
   parameter int TIMEOUT_W  = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bist_start,
   input  logic                  bist_abort,
   input  logic [NUM_MEM-1:0]    mem_mask,
   input  logic                  cfg_error_exceed_ignore,
   input  logic [ADDR_WIDTH-1:0] cfg_allowable_faulty,
   output logic                  marchc_en,
   output logic [4:0]            memtype,
   output logic                  error_exceed_ignore,
   output logic [ADDR_WIDTH-1:0] allowable_faulty,
   input  logic                  error,
   input  logic                  force_terminate,
   input  logic                  marchc_complete,
   output logic                  bist_busy,
   output logic                  bist_done,
   output logic                  bist_pass,
   output logic [NUM_MEM-1:0]    fail_map,
   output logic [NUM_MEM-1:0]    timeout_map
);

   // state   | meaning
   // IDLE    | waiting for bist_start
   // SELECT  | scanning the mask for the next memory at idx
   // RUN     | decoder enabled on memtype idx, watchdog counting
   // RELEASE | one-cycle enable gap so the decoder re-arms
   // DONE    | one-cycle verdict pulse
   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_RUN, S_RELEASE, S_DONE} state_t;

   localparam logic [4:0]           LAST_IDX = 5'(NUM_MEM - 1);
   // The watchdog fires on the increment that would make it all-ones.
   localparam logic [TIMEOUT_W-1:0] WD_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_t                 state, next_state;
   logic [4:0]             idx;
   logic [TIMEOUT_W-1:0]   watchdog;
   logic [NUM_MEM-1:0]     mask_q;
   logic [NUM_MEM-1:0]     sel_hot;
   logic                   mask_hit, is_last, wd_expire, run_flag, run_exit, abort_now;

   assign sel_hot   = NUM_MEM'(1) << idx;
   assign mask_hit  = |(mask_q & sel_hot);
   assign is_last   = (idx == LAST_IDX);
   assign wd_expire = (state == S_RUN) && (watchdog == WD_LAST);
   assign run_flag  = (state == S_RUN) && (error | force_terminate | wd_expire);
   assign run_exit  = force_terminate | marchc_complete | wd_expire;
   assign abort_now = bist_abort && (state inside {S_SELECT, S_RUN, S_RELEASE});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:    if (bist_start) next_state = S_SELECT;
         S_SELECT: begin
            if (bist_abort)    next_state = S_DONE;
            else if (mask_hit) next_state = S_RUN;
            else if (is_last)  next_state = S_DONE;
         end
         S_RUN: begin
            if (bist_abort)    next_state = S_DONE;
            else if (run_exit) next_state = S_RELEASE;
         end
         S_RELEASE: begin
            if (bist_abort || is_last) next_state = S_DONE;
            else                       next_state = S_SELECT;
         end
         S_DONE:    next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx                 <= '0;
         watchdog            <= '0;
         mask_q              <= '0;
         marchc_en           <= 1'b0;
         memtype             <= '0;
         error_exceed_ignore <= 1'b0;
         allowable_faulty    <= '0;
         bist_busy           <= 1'b0;
         bist_done           <= 1'b0;
         bist_pass           <= 1'b0;
         fail_map            <= '0;
         timeout_map         <= '0;
      end else begin
         marchc_en <= (next_state == S_RUN);
         bist_busy <= (next_state != S_IDLE);
         bist_done <= (next_state == S_DONE);
         case (state)
            S_IDLE: begin
               if (bist_start) begin
                  mask_q              <= mem_mask;
                  error_exceed_ignore <= cfg_error_exceed_ignore;
                  allowable_faulty    <= cfg_allowable_faulty;
                  fail_map            <= '0;
                  timeout_map         <= '0;
                  bist_pass           <= 1'b0;
                  idx                 <= '0;
               end
            end
            S_SELECT: begin
               if (next_state == S_RUN) begin
                  memtype  <= idx;
                  watchdog <= '0;
               end else if (next_state == S_SELECT) begin
                  idx <= idx + 1'b1;
               end
            end
            S_RUN: begin
               watchdog <= watchdog + 1'b1;
               if (run_flag)  fail_map    <= fail_map | sel_hot;
               if (wd_expire) timeout_map <= timeout_map | sel_hot;
            end
            S_RELEASE: begin
               if (next_state == S_SELECT) idx <= idx + 1'b1;
            end
            default: ;
         endcase
         // DONE is only entered from the walk states; an abort there forces a fail.
         if (next_state == S_DONE)
            bist_pass <= !abort_now && (fail_map == '0);
      end
   end

endmodule

// File: tb/tb_mbist_sequencer.sv
// Randomized scoreboard bench for mbist_sequencer with a behavioural decoder model.
module tb_mbist_sequencer;
   localparam int NM     = 8;
   localparam int AW     = 16;
   localparam int TW     = 4;
   localparam int WD_CYC = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          bist_start, start_drv, start_noise;
   logic          bist_abort;
   logic [NM-1:0] mem_mask;
   logic          cfg_eei;
   logic [AW-1:0] cfg_af;
   logic          marchc_en;
   logic [4:0]    memtype;
   logic          error_exceed_ignore;
   logic [AW-1:0] allowable_faulty;
   logic          err_d, force_d, comp_d;
   logic          bist_busy, bist_done, bist_pass;
   logic [NM-1:0] fail_map, timeout_map;

   assign bist_start = start_drv | start_noise;

   mbist_sequencer #(.ADDR_WIDTH(AW), .NUM_MEM(NM), .TIMEOUT_W(TW)) dut (
      .clk(clk), .rst(rst), .bist_start(bist_start), .bist_abort(bist_abort),
      .mem_mask(mem_mask), .cfg_error_exceed_ignore(cfg_eei), .cfg_allowable_faulty(cfg_af),
      .marchc_en(marchc_en), .memtype(memtype), .error_exceed_ignore(error_exceed_ignore),
      .allowable_faulty(allowable_faulty), .error(err_d), .force_terminate(force_d),
      .marchc_complete(comp_d), .bist_busy(bist_busy), .bist_done(bist_done),
      .bist_pass(bist_pass), .fail_map(fail_map), .timeout_map(timeout_map));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int mt; int len; logic eei; logic [AW-1:0] af;} run_t;
   typedef struct {int done_cyc; logic pass; logic [NM-1:0] fmap; logic [NM-1:0] tmap;} ses_t;
   run_t rq[$];
   ses_t sq[$];

   // Per-memory decoder behaviour, RUN-cycle numbers starting at 1 (0 = never).
   int comp_at[NM], force_at[NM], err_at[NM];
   int abort_mem = -1, abort_k = 0;
   int n_checks = 0, n_fail = 0, n_done = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Decoder model; drives random noise whenever the sequencer is not in RUN.
   int dcnt = 0, dmt = 0;
   always @(negedge clk) begin
      err_d = 1'b0; force_d = 1'b0; comp_d = 1'b0; bist_abort = 1'b0; start_noise = 1'b0;
      if (rst) begin
         dcnt = 0;
      end else if (marchc_en) begin
         dcnt++;
         dmt = int'(memtype);
         if (dmt < NM) begin
            err_d      = (err_at[dmt] == dcnt);
            force_d    = (force_at[dmt] == dcnt);
            comp_d     = (comp_at[dmt] == dcnt);
            bist_abort = (abort_mem == dmt) && (abort_k == dcnt);
         end
         start_noise = ($urandom_range(7) == 0);
      end else begin
         dcnt        = 0;
         err_d       = ($urandom_range(3) == 0);
         force_d     = ($urandom_range(3) == 0);
         comp_d      = ($urandom_range(3) == 0);
         bist_abort  = !bist_busy && ($urandom_range(2) == 0);
         start_noise = bist_busy && ($urandom_range(7) == 0);
      end
   end

   // Monitor: pops expectations when a run starts/ends and when bist_done pulses.
   logic en_prev = 1'b0, post = 1'b0, pexp = 1'b0;
   int   rlen = 0;
   run_t cr;
   ses_t cs;
   always @(negedge clk) begin
      if (rst) begin
         en_prev = 1'b0; post = 1'b0; rlen = 0;
      end else begin
         if (marchc_en && !en_prev) begin
            if (rq.size() == 0) begin
               chk("unexpected_run", marchc_en, 0);
               cr.len = -1;
            end else begin
               cr = rq.pop_front();
               chk("memtype", memtype, cr.mt);
               chk("error_exceed_ignore", error_exceed_ignore, cr.eei);
               chk("allowable_faulty", allowable_faulty, cr.af);
            end
            rlen = 1;
         end else if (marchc_en) begin
            rlen++;
         end else if (en_prev) begin
            chk("run_len", rlen, cr.len);
         end
         if (bist_done) begin
            if (sq.size() == 0) begin
               chk("unexpected_done", bist_done, 0);
            end else begin
               cs = sq.pop_front();
               chk("done_cycle", cyc, cs.done_cyc);
               chk("bist_pass", bist_pass, cs.pass);
               chk("fail_map", fail_map, cs.fmap);
               chk("timeout_map", timeout_map, cs.tmap);
               chk("busy_at_done", bist_busy, 1);
               chk("runs_left", rq.size(), 0);
               pexp = cs.pass;
               post = 1'b1;
            end
            n_done++;
         end else if (post) begin
            chk("busy_after_done", bist_busy, 0);
            chk("done_one_cycle", bist_done, 0);
            chk("pass_held", bist_pass, pexp);
            post = 1'b0;
         end
         en_prev = marchc_en;
      end
   end

   task automatic wait_idle();
      for (int k = 0; k < 500 && bist_busy; k++) @(negedge clk);
      if (bist_busy) chk("idle_timeout", bist_busy, 0);
   endtask

   task automatic set_beh(input int i, input int c, input int f, input int e);
      comp_at[i] = c; force_at[i] = f; err_at[i] = e;
   endtask

   // Reference model: the walk costs one cycle per index, plus run length and a
   // release cycle per selected memory; DONE follows the last consumed cycle.
   task automatic session(input logic [NM-1:0] m, input logic eei, input logic [AW-1:0] af,
                          input int extra_start_at);
      int cur, e, start_done;
      logic ab;
      logic [NM-1:0] fm, tm;
      run_t r;
      ses_t s;
      @(negedge clk);
      wait_idle();
      cur = cyc; ab = 1'b0; fm = '0; tm = '0;
      for (int i = 0; i < NM; i++) begin
         if (ab) break;
         cur++;
         if (!m[i]) continue;
         r.mt = i; r.eei = eei; r.af = af;
         if (abort_mem == i) begin
            r.len = abort_k; cur += abort_k; ab = 1'b1;
         end else begin
            e = WD_CYC;
            if (comp_at[i] != 0 && comp_at[i] < e) e = comp_at[i];
            if (force_at[i] != 0 && force_at[i] < e) e = force_at[i];
            if ((err_at[i] != 0 && err_at[i] <= e) || (force_at[i] != 0 && force_at[i] <= e)
                || e == WD_CYC) fm[i] = 1'b1;
            if (e == WD_CYC) tm[i] = 1'b1;
            r.len = e; cur += e + 1;
         end
         rq.push_back(r);
      end
      s.done_cyc = cur + 1; s.pass = (fm == '0) && !ab; s.fmap = fm; s.tmap = tm;
      sq.push_back(s);
      start_done = n_done;
      start_drv = 1'b1; mem_mask = m; cfg_eei = eei; cfg_af = af;
      @(negedge clk);
      start_drv = 1'b0; mem_mask = NM'($urandom); cfg_eei = ~eei; cfg_af = AW'($urandom);
      for (int k = 0; k < 3000; k++) begin
         if (n_done > start_done) break;
         start_drv = (k == extra_start_at);
         @(negedge clk);
      end
      start_drv = 1'b0;
      if (n_done <= start_done) begin
         chk("done_timeout", n_done, start_done + 1);
         rq.delete(); sq.delete();
      end
      abort_mem = -1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_marchc_en"}, marchc_en, 0);
      chk({tag, "_memtype"}, memtype, 0);
      chk({tag, "_eei"}, error_exceed_ignore, 0);
      chk({tag, "_af"}, allowable_faulty, 0);
      chk({tag, "_busy"}, bist_busy, 0);
      chk({tag, "_done"}, bist_done, 0);
      chk({tag, "_pass"}, bist_pass, 0);
      chk({tag, "_fail_map"}, fail_map, 0);
      chk({tag, "_timeout_map"}, timeout_map, 0);
   endtask

   initial begin
      logic [NM-1:0] m;
      rst = 1'b1; start_drv = 1'b0; mem_mask = '0; cfg_eei = 1'b0; cfg_af = '0;
      for (int i = 0; i < NM; i++) set_beh(i, 10, 0, 0);
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      session(8'b0000_0101, 1'b1, 16'h00A5, -1);
      set_beh(1, 10, 0, 10);
      session(8'b0000_0011, 1'b0, 16'h1234, -1);
      set_beh(0, 0, 0, 0);
      session(8'b0000_0001, 1'b1, 16'hFFFF, -1);
      set_beh(7, 5, 5, 0);
      session(8'b1000_0000, 1'b0, 16'h0001, -1);
      session(8'b0000_0000, 1'b1, 16'h7777, 3);

      set_beh(1, 8, 0, 3); set_beh(3, 0, 0, 0);
      abort_mem = 3; abort_k = 6;
      session(8'b0000_1010, 1'b1, 16'h3C3C, -1);

      // Reset in the middle of a fresh session's run on memtype 6.
      set_beh(6, 0, 0, 0);
      @(negedge clk);
      wait_idle();
      rq.push_back('{mt: 6, len: 0, eei: 1'b1, af: 16'hBEEF});
      start_drv = 1'b1; mem_mask = 8'b0100_0000; cfg_eei = 1'b1; cfg_af = 16'hBEEF;
      @(negedge clk);
      start_drv = 1'b0;
      for (int k = 0; k < 100 && !marchc_en; k++) @(negedge clk);
      chk("reset_test_running", marchc_en, 1);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_outputs("midrun_reset");
      rq.delete(); sq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int s = 0; s < 40; s++) begin
         m = NM'($urandom);
         for (int i = 0; i < NM; i++)
            set_beh(i, ($urandom_range(4) == 0) ? 0 : int'($urandom_range(1, 18)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(1, 18)) : 0,
                    ($urandom_range(3) == 0) ? int'($urandom_range(1, 18)) : 0);
         if ($urandom_range(4) == 0) begin
            abort_mem = int'($urandom_range(NM - 1));
            abort_k   = int'($urandom_range(1, 14));
            m[abort_mem] = 1'b1;
            set_beh(abort_mem, 0, 0, 0);
         end
         session(m, 1'($urandom), AW'($urandom), -1);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/mbist_sequencer.md
# mbist_sequencer

Top-level memory-BIST sequencer that sits directly upstream of the March C decoder. It walks a configurable set of memory types and, for each one, drives the decoder's enable, memtype and fault-policy inputs. It collects the decoder's error, force_terminate and completion outputs into per-memory result maps, guards every run with a watchdog, and reports one overall pass/fail verdict per BIST session.

## Interface
- ADDR_WIDTH, 16, width of the allowable_faulty threshold; matches the decoder.
- NUM_MEM, 8, number of selectable memory types; legal range 1..32; index i drives memtype = i.
- TIMEOUT_W, 24, watchdog width; a run aborts after 2^TIMEOUT_W - 1 cycles without completion.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bist_start  in  1  one-cycle start pulse; sampled only in IDLE.
- bist_abort  in  1  level; while high, forces the session to finish.
- mem_mask  in  NUM_MEM  bit i = 1 tests memtype i; sampled on the accepted bist_start.
- cfg_error_exceed_ignore  in  1  policy forwarded to the decoder; sampled on start.
- cfg_allowable_faulty  in  ADDR_WIDTH  fault threshold forwarded to the decoder; sampled on start.
- marchc_en  out  1  decoder enable.
- memtype  out  5  memory type under test.
- error_exceed_ignore  out  1  registered copy of cfg_error_exceed_ignore.
- allowable_faulty  out  ADDR_WIDTH  registered copy of cfg_allowable_faulty.
- error  in  1  decoder per-read mismatch flag.
- force_terminate  in  1  decoder fault-limit abort.
- marchc_complete  in  1  decoder completion.
- bist_busy  out  1  high from the cycle after an accepted start until DONE exits.
- bist_done  out  1  one-cycle pulse in DONE.
- bist_pass  out  1  valid with bist_done and held after it.
- fail_map  out  NUM_MEM  bit i = memtype i saw an error, a terminate or a timeout.
- timeout_map  out  NUM_MEM  bit i = memtype i hit the watchdog.

## Operation
- All outputs are registered. On reset:
  - state = IDLE, idx = 0, watchdog = 0;
  - marchc_en = 0, memtype = 0;
  - error_exceed_ignore = 0, allowable_faulty = 0;
  - bist_busy = 0, bist_done = 0, bist_pass = 0;
  - fail_map = 0, timeout_map = 0.
- FSM states: IDLE, SELECT, RUN, RELEASE, DONE.
- IDLE:
  - bist_start = 1 latches the mask and config, clears fail_map, timeout_map and bist_pass, sets idx = 0, and goes to SELECT.
  - bist_start in any other state is ignored.
- SELECT:
  - If mask[idx] = 1: set memtype = idx, clear the watchdog, go to RUN. marchc_en rises on entry to RUN.
  - Else if idx = NUM_MEM-1: go to DONE.
  - Else: idx++ and stay in SELECT. The scan costs one cycle per skipped index.
- RUN: marchc_en = 1, watchdog increments every cycle.
  - error = 1 in any RUN cycle, including the completion cycle, sets fail_map[idx].
  - force_terminate = 1 sets fail_map[idx]; leave through RELEASE.
  - marchc_complete = 1 leaves through RELEASE.
  - Watchdog reaching all-ones sets fail_map[idx] and timeout_map[idx]; leave through RELEASE.
  - When several of these fire in the same cycle, all flags are recorded and a single RELEASE follows.
- RELEASE: marchc_en = 0 for exactly one cycle so the decoder re-arms.
  - Next state is DONE if idx = NUM_MEM-1, otherwise SELECT with idx+1.
- DONE:
  - bist_done = 1 for one cycle; bist_pass = (fail_map == 0) and no abort occurred this session.
  - Then IDLE. fail_map, timeout_map and bist_pass hold until the next accepted start.
- bist_abort = 1 in SELECT, RUN or RELEASE: the next state is DONE, marchc_en drops, bist_pass = 0. Flags already recorded are kept.
- bist_abort has no effect in IDLE.
- Error and completion inputs are ignored outside RUN.
- Empty mask: the scan completes with bist_pass = 1.

## Timing
- Start pulse at cycle T, mask bit 0 set: SELECT at T+1, marchc_en = 1 and memtype = 0 at T+2.
- marchc_complete at cycle C: marchc_en = 0 at C+1 (RELEASE). The next selected memtype j > idx raises marchc_en at C+3+(j-idx-1).
- Last memtype completes at C: bist_done at C+2, bist_busy low at C+3.
- Abort sampled at A: DONE at A+1, marchc_en low at A+1.
- Reset asserted mid-run clears everything asynchronously. marchc_en is low in the same cycle.

## Test plan
- mask = 8'b0000_0101, decoder model completes each run after 10 cycles with no errors -> memtype sequence 0 then 2, two RELEASE gaps, bist_done with bist_pass = 1, fail_map = 0.
- mask = 8'b0000_0011, error pulsed on the completion cycle of memtype 1 -> fail_map = 8'b0000_0010, bist_pass = 0.
- mask = 8'b0000_0001, TIMEOUT_W = 4, decoder never completes -> marchc_en drops after 15 RUN cycles, timeout_map = fail_map = 8'b0000_0001.
- mask = 8'b1000_0000, force_terminate plus marchc_complete in the same cycle -> a single RELEASE, fail_map[7] = 1, bist_done 2 cycles later.
- mask = 0 -> bist_done 9 cycles after start (8 SELECT cycles plus DONE), bist_pass = 1. A second bist_start while busy is ignored.
- bist_abort during RUN on memtype 3, then rst asserted mid-run on a new session -> first: DONE next cycle with bist_pass = 0; second: all outputs return to their reset values immediately.
